sdf_gs_stage: RTL and testbench

SDF_GS_STAGE -- requirements
Module: sdf_gs_stage

---
 rtl/sdf_gs_stage.sv | 120 ++++++++++++
 tb/tb_sdf_gs_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sdf_gs_stage.sv
// Radix-2 Gentleman-Sande single-path delay-feedback stage (mod-q).
// Sums leave at once; differences recirculate through the delay line.
module sdf_gs_stage #(
    parameter int LOGQ       = 0,
    parameter int LOGD       = 0,
    parameter int IS_Q_FIXED = 0,
    parameter int Q          = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LOGQ-1:0] q,
    input  logic [LOGQ-1:0] din,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_flush,
    output logic [LOGQ-1:0] dout,
    output logic            out_valid
);

    localparam int W  = (LOGQ < 1) ? 2 : LOGQ;
    localparam int D  = 1 << LOGD;
    localparam int CW = LOGD + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          primed;

    logic [W-1:0]  qv;
    logic [W-1:0]  dw;
    logic [W-1:0]  y;
    logic [W-1:0]  push;
    logic [W:0]    sum_raw;
    logic [W:0]    sum_mod;
    logic [W:0]    dif;
    logic          accept;
    logic          shift_en;
    logic          phase;

    logic [W-1:0]  dl [D];

    assign qv       = (IS_Q_FIXED != 0) ? W'(Q) : q;
    assign dw       = din;
    assign y        = dl[D-1];
    assign phase    = cnt[LOGD];
    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign shift_en = accept || (state == DRAIN);

    always_comb begin
        sum_raw = {1'b0, y} + {1'b0, dw};
        sum_mod = sum_raw;
        if (sum_raw >= {1'b0, qv})
            sum_mod = sum_raw - {1'b0, qv};
        dif = {1'b0, y} - {1'b0, dw};
        if (y < dw)
            dif = {1'b0, y} + {1'b0, qv} - {1'b0, dw};
    end

    always_comb begin
        push = dw;
        if (state == DRAIN)
            push = '0;
        else if (phase)
            push = dif[W-1:0];
    end

    // Contents are never read as valid output before a full block refills them.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            dl[0] <= push;
            for (int i = 1; i < D; i++)
                dl[i] <= dl[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            primed    <= 1'b0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1)
                            primed <= 1'b1;
                        if (phase) begin
                            dout      <= sum_mod[W-1:0];
                            out_valid <= 1'b1;
                        end else begin
                            dout      <= y;
                            out_valid <= primed;
                        end
                    end else if (in_flush && cnt == '0 && primed) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    dout      <= y;
                    out_valid <= 1'b1;
                    if (cnt == CW'(D - 1)) begin
                        state  <= RUN;
                        cnt    <= '0;
                        primed <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_gs_stage.sv
// Bench for sdf_gs_stage: directed q=7681 D=2 cases plus a
// random fixed-Q (12289) D=8 stream, both against a block-level model.
module tb_sdf_gs_stage;

    localparam int LQ = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [LQ-1:0] q0, din0, dout0, q1, din1, dout1;
    logic v0, f0, r0, ov0, v1, f1, r1, ov1;

    sdf_gs_stage #(.LOGQ(LQ), .LOGD(1), .IS_Q_FIXED(0), .Q(0)) u0 (
        .clk(clk), .rst_n(rst_n), .q(q0), .din(din0),
        .in_valid(v0), .in_ready(r0), .in_flush(f0),
        .dout(dout0), .out_valid(ov0)
    );

    sdf_gs_stage #(.LOGQ(LQ), .LOGD(3), .IS_Q_FIXED(1), .Q(12289)) u1 (
        .clk(clk), .rst_n(rst_n), .q(q1), .din(din1),
        .in_valid(v1), .in_ready(r1), .in_flush(f1),
        .dout(dout1), .out_valid(ov1)
    );

    int cmp = 0;
    int bad = 0;

    task automatic check(string nm, int act, int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Block-level model: buffer a block, emit sums on arrival of x(i+D),
    // hand the differences to the next block's first half or to a drain.
    int md[2], mq[2], pos[2], drn[2], hp[2];
    int xb[2][16];
    int pend[2][8];
    int nd[2][8];
    int ev[2], ed[2], er[2];

    task automatic step(int k, bit v, int d, bit fl);
        int i;
        ev[k] = 0;
        if (!rst_n) begin
            pos[k] = 0; drn[k] = 0; hp[k] = 0; er[k] = 1;
            return;
        end
        if (drn[k] > 0) begin
            ev[k] = 1;
            ed[k] = pend[k][md[k] - drn[k]];
            drn[k]--;
            if (drn[k] == 0) hp[k] = 0;
        end else if (v) begin
            if (pos[k] < md[k]) begin
                xb[k][pos[k]] = d;
                if (hp[k] != 0) begin
                    ev[k] = 1;
                    ed[k] = pend[k][pos[k]];
                end
            end else begin
                i = pos[k] - md[k];
                ev[k] = 1;
                ed[k] = (xb[k][i] + d) % mq[k];
                nd[k][i] = (xb[k][i] - d + mq[k]) % mq[k];
            end
            pos[k]++;
            if (pos[k] == 2 * md[k]) begin
                pos[k] = 0;
                for (int j = 0; j < md[k]; j++) pend[k][j] = nd[k][j];
                hp[k] = 1;
            end
        end else if (fl && pos[k] == 0 && hp[k] != 0) begin
            drn[k] = md[k];
        end
        er[k] = (drn[k] == 0) ? 1 : 0;
    endtask

    int got0[$];

    always @(posedge clk) begin
        step(0, v0, int'(din0), f0);
        step(1, v1, int'(din1), f1);
        #1;
        check("ov0", ov0, ev[0]);
        if (ev[0] != 0) check("dout0", dout0, ed[0]);
        check("rdy0", r0, er[0]);
        check("ov1", ov1, ev[1]);
        if (ev[1] != 0) check("dout1", dout1, ed[1]);
        check("rdy1", r1, er[1]);
        if (!rst_n) begin
            check("rst_dout0", dout0, 0);
            check("rst_dout1", dout1, 0);
        end
        if (ov0) got0.push_back(int'(dout0));
    end

    int el[8];

    task automatic chk_list(string nm, int n);
        check({nm, "_len"}, got0.size(), n);
        for (int i = 0; i < n; i++)
            if (i < got0.size()) check(nm, got0[i], el[i]);
        got0.delete();
    endtask

    task automatic send0(int d);
        @(negedge clk);
        v0 = 1'b1; din0 = LQ'(d); f0 = 1'b0;
    endtask

    task automatic sendf0(int d);
        @(negedge clk);
        v0 = 1'b1; din0 = LQ'(d); f0 = 1'b1;
    endtask

    task automatic flush0();
        @(negedge clk);
        v0 = 1'b0; f0 = 1'b1;
    endtask

    task automatic idle0(int n);
        repeat (n) begin
            @(negedge clk);
            v0 = 1'b0; f0 = 1'b0;
        end
    endtask

    initial begin
        md[0] = 2; mq[0] = 7681;
        md[1] = 8; mq[1] = 12289;
        q0 = LQ'(7681); q1 = '0;
        din0 = '0; din1 = '0;
        v0 = 1'b0; f0 = 1'b0; v1 = 1'b0; f1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ov", ov0, 0);
        check("rst_dout", dout0, 0);
        check("rst_rdy", r0, 1);
        fork
            begin
                idle0(2);
                got0.delete();
                send0(1); send0(2); send0(3); send0(4);
                flush0(); idle0(6);
                el = '{4, 6, 7679, 7679, 0, 0, 0, 0};
                chk_list("s_basic", 4);

                send0(7680); send0(7680); send0(5); send0(0);
                flush0(); idle0(6);
                el = '{4, 7680, 7675, 7680, 0, 0, 0, 0};
                chk_list("s_wrap", 4);

                for (int i = 1; i <= 8; i++) send0(i);
                flush0(); idle0(6);
                el = '{4, 6, 7679, 7679, 12, 14, 7679, 7679};
                chk_list("s_b2b", 8);

                send0(1); send0(2); send0(3); send0(4);
                sendf0(10);
                flush0();
                send0(20); send0(30); send0(40);
                flush0(); idle0(6);
                el = '{4, 6, 7679, 7679, 40, 60, 7661, 7661};
                chk_list("s_ignflush", 8);

                send0(1); send0(2); send0(3); send0(4);
                flush0(); idle0(1);
                @(negedge clk);
                rst_n = 1'b0; v0 = 1'b0; f0 = 1'b0;
                #1;
                check("rst_drain_ov", ov0, 0);
                check("rst_drain_rdy", r0, 1);
                el = '{4, 6, 7679, 0, 0, 0, 0, 0};
                chk_list("s_prerst", 3);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                send0(1); send0(2); send0(3); send0(4);
                idle0(8);
                el = '{4, 6, 0, 0, 0, 0, 0, 0};
                chk_list("s_postrst", 2);
            end
            begin
                repeat (3000) begin
                    @(negedge clk);
                    v1 = ($urandom_range(0, 3) != 0);
                    din1 = LQ'($urandom_range(0, 12288));
                    f1 = ($urandom_range(0, 3) == 0);
                end
                @(negedge clk);
                v1 = 1'b0; f1 = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
